// File: rtl/lock_key_pkg.sv
// Shared widths, CRC polynomial and loader state encoding for the c432 key loader.
// Lockout-related constants are used only when LOCK_KEY_LOCKOUT_EN is defined.
package lock_key_pkg;
   localparam int MUX_KEY_W = 4;
   localparam int XOR_KEY_W = 20;
   localparam int CHK_W     = 8;
   localparam int MAX_FAIL  = 3;
   localparam int KEY_W     = MUX_KEY_W + XOR_KEY_W;
   localparam int FRAME_W   = KEY_W + CHK_W;

   localparam logic [CHK_W-1:0] CRC8_POLY = 8'h07;

   localparam int CNT_W = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] KEY_END  = CNT_W'(KEY_W);

   localparam int FAIL_CNT_W = $clog2(MAX_FAIL + 1);
   localparam logic [FAIL_CNT_W-1:0] FAIL_LAST = FAIL_CNT_W'(MAX_FAIL - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CHECK,
      ARMED,
      FAIL,
      LOCKED
   } lk_state_e;
endpackage

// File: rtl/lock_key_crc8.sv
// Serial CRC-8 (MSB first, init 0, no reflection/xorout); clear has priority over enable.
module lock_key_crc8
   import lock_key_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [CHK_W-1:0] rem
);
   logic [CHK_W-1:0] crc_reg;
   logic [CHK_W-1:0] crc_next;
   logic             fb;

   assign fb = crc_reg[CHK_W-1] ^ din;
   assign crc_next[0] = fb & CRC8_POLY[0];

   genvar gi;
   generate
      for (gi = 1; gi < CHK_W; gi++) begin : g_crc_bit
         assign crc_next[gi] = crc_reg[gi-1] ^ (fb & CRC8_POLY[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         crc_reg <= '0;
      end else if (en) begin
         crc_reg <= crc_next;
      end
   end

   assign rem = crc_reg;
endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader for the locked c432: assembles a 24-bit key + CRC-8 frame and releases the key only once verified.
// Optional lockout after repeated CRC failures is enabled by defining LOCK_KEY_LOCKOUT_EN.
module lock_key_loader
   import lock_key_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_start,
   input  logic                 ser_valid,
   input  logic                 ser_data,
   output logic                 ser_ready,
   output logic [MUX_KEY_W-1:0] key_p,
   output logic [XOR_KEY_W-1:0] key_x,
   output logic                 key_valid,
   output logic                 busy,
   output logic                 err
`ifdef LOCK_KEY_LOCKOUT_EN
   ,
   output logic                 locked_out
`endif
);
   lk_state_e            state_reg, state_next;
   logic [CNT_W-1:0]     bit_cnt_reg;
   logic [FRAME_W-1:0]   frame_reg;
   logic [MUX_KEY_W-1:0] key_p_reg;
   logic [XOR_KEY_W-1:0] key_x_reg;
   logic                 key_valid_reg;
   logic                 err_reg;
   logic                 restart;
   logic                 beat;
   logic                 crc_pass;
   logic [CHK_W-1:0]     crc_rem;
`ifdef LOCK_KEY_LOCKOUT_EN
   logic [FAIL_CNT_W-1:0] fail_cnt_reg;
`endif

   // Only the key portion of the frame feeds the CRC; the trailing 8 bits are the received check value.
   lock_key_crc8 u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (restart),
      .en    (beat && (bit_cnt_reg < KEY_END)),
      .din   (ser_data),
      .rem   (crc_rem)
   );

   assign crc_pass = (crc_rem == frame_reg[CHK_W-1:0]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      restart    = 1'b0;
      beat       = 1'b0;
      case (state_reg)
         IDLE, ARMED, FAIL: begin
            if (load_start) begin
               restart    = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // A restart in the same cycle as a beat drops that bit.
            if (load_start) begin
               restart = 1'b1;
            end else if (ser_valid) begin
               beat = 1'b1;
               if (bit_cnt_reg == LAST_BIT) begin
                  state_next = CHECK;
               end
            end
         end
         CHECK: begin
            if (crc_pass) begin
               state_next = ARMED;
            end else begin
`ifdef LOCK_KEY_LOCKOUT_EN
               state_next = (fail_cnt_reg == FAIL_LAST) ? LOCKED : FAIL;
`else
               state_next = FAIL;
`endif
            end
         end
         LOCKED: state_next = LOCKED;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt_reg   <= '0;
         frame_reg     <= '0;
         key_p_reg     <= '0;
         key_x_reg     <= '0;
         key_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         // Key outputs deliberately hold across a restart so the locked core never sees partial data.
         if (restart) begin
            bit_cnt_reg   <= '0;
            frame_reg     <= '0;
            key_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
         end else if (beat) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            frame_reg   <= {frame_reg[FRAME_W-2:0], ser_data};
         end
         if (state_reg == CHECK) begin
            if (crc_pass) begin
               key_p_reg     <= frame_reg[FRAME_W-1 -: MUX_KEY_W];
               key_x_reg     <= frame_reg[CHK_W +: XOR_KEY_W];
               key_valid_reg <= 1'b1;
               err_reg       <= 1'b0;
            end else begin
               key_p_reg     <= '0;
               key_x_reg     <= '0;
               key_valid_reg <= 1'b0;
               err_reg       <= 1'b1;
            end
         end
      end
   end

`ifdef LOCK_KEY_LOCKOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fail_cnt_reg <= '0;
      end else if (state_reg == CHECK) begin
         fail_cnt_reg <= crc_pass ? '0 : fail_cnt_reg + 1'b1;
      end
   end

   assign locked_out = (state_reg == LOCKED);
`endif

   assign ser_ready = (state_reg == SHIFT);
   assign busy      = (state_reg == SHIFT) || (state_reg == CHECK);
   assign key_p     = key_p_reg;
   assign key_x     = key_x_reg;
   assign key_valid = key_valid_reg;
   assign err       = err_reg;
endmodule

// File: tb/tb_lock_key_loader.sv
// Directed self-checking bench for lock_key_loader; lockout steps run when LOCK_KEY_LOCKOUT_EN is defined.
module tb_lock_key_loader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start;
   logic        ser_valid;
   logic        ser_data;
   logic        ser_ready;
   logic [3:0]  key_p;
   logic [19:0] key_x;
   logic        key_valid;
   logic        busy;
   logic        err;
`ifdef LOCK_KEY_LOCKOUT_EN
   logic        locked_out;
`endif

   int checks = 0;
   int errors = 0;

   lock_key_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .ser_valid  (ser_valid),
      .ser_data   (ser_data),
      .ser_ready  (ser_ready),
      .key_p      (key_p),
      .key_x      (key_x),
      .key_valid  (key_valid),
      .busy       (busy),
      .err        (err)
`ifdef LOCK_KEY_LOCKOUT_EN
      ,
      .locked_out (locked_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   // Sends the top nbits of frame MSB first; with gaps, idle cycles precede each bit and held outputs are checked.
   task automatic send_bits(input logic [31:0] frame, input int nbits, input bit gaps,
                            input logic [19:0] hold_x);
      chk("ser_ready_at_send", ser_ready, 1'b1);
      for (int i = 31; i > 31 - nbits; i--) begin
         if (gaps) begin
            ser_valid = 1'b0;
            ser_data  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) tick();
            chk("hold_key_x", key_x, hold_x);
            chk("hold_key_valid", key_valid, 1'b0);
         end
         ser_valid = 1'b1;
         ser_data  = frame[i];
         tick();
         ser_valid = 1'b0;
      end
   endtask

   task automatic run_frame(input logic [31:0] frame);
      pulse_start();
      send_bits(frame, 32, 1'b0, 20'h0);
      tick();
      tick();
   endtask

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      ser_valid  = 1'b0;
      ser_data   = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_key_p", key_p, 4'h0);
      chk("rst_key_x", key_x, 20'h0);
      chk("rst_key_valid", key_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_ser_ready", ser_ready, 1'b0);
      $display("reset: checks done");

      // 1: all-zero key with CRC 00, latency check
      pulse_start();
      chk("t1_busy", busy, 1'b1);
      send_bits({24'h000000, 8'h00}, 32, 1'b0, 20'h0);
      chk("t1_check_valid", key_valid, 1'b0);
      chk("t1_check_busy", busy, 1'b1);
      chk("t1_check_ready", ser_ready, 1'b0);
      tick();
      chk("t1_valid", key_valid, 1'b1);
      chk("t1_key_p", key_p, 4'h0);
      chk("t1_key_x", key_x, 20'h0);
      chk("t1_err", err, 1'b0);
      chk("t1_busy_done", busy, 1'b0);
      $display("txn 1: key 000000 crc 00 key_valid=%0b", key_valid);

      // 2: key 000001, good CRC 07 then bad CRC 06
      run_frame({24'h000001, 8'h07});
      chk("t2_pass_valid", key_valid, 1'b1);
      chk("t2_pass_key_x", key_x, 20'h00001);
      run_frame({24'h000001, 8'h06});
      chk("t2_fail_err", err, 1'b1);
      chk("t2_fail_key_p", key_p, 4'h0);
      chk("t2_fail_key_x", key_x, 20'h0);
      chk("t2_fail_valid", key_valid, 1'b0);
      pulse_start();
      chk("t2_err_cleared", err, 1'b0);
      $display("txn 2: key 000001 good/bad crc, err cleared on restart");

      // 3: outputs hold the armed key during a gappy reload
      send_bits({24'h000001, 8'h07}, 32, 1'b0, 20'h0);
      tick();
      tick();
      chk("t3_armed_x", key_x, 20'h00001);
      pulse_start();
      chk("t3_valid_drop", key_valid, 1'b0);
      chk("t3_hold_x", key_x, 20'h00001);
      send_bits({24'h000002, 8'h0E}, 32, 1'b1, 20'h00001);
      chk("t3_check_hold_x", key_x, 20'h00001);
      tick();
      chk("t3_new_x", key_x, 20'h00002);
      chk("t3_new_valid", key_valid, 1'b1);
      $display("txn 3: gappy reload, key_x=%h", key_x);

      // 4: restart at bit 17, with a simultaneous beat that must be dropped
      pulse_start();
      send_bits({24'h100000, 8'hA2}, 17, 1'b0, 20'h0);
      load_start = 1'b1;
      ser_valid  = 1'b1;
      ser_data   = 1'b1;
      tick();
      load_start = 1'b0;
      ser_valid  = 1'b0;
      send_bits({24'hF00001, 8'h6B}, 32, 1'b0, 20'h0);
      tick();
      chk("t4_valid", key_valid, 1'b1);
      chk("t4_key_p", key_p, 4'hF);
      chk("t4_key_x", key_x, 20'h00001);
      chk("t4_err", err, 1'b0);
      $display("txn 4: restart mid-frame, key_p=%h key_x=%h", key_p, key_x);

      // 5: reset at bit 20, then a clean frame
      pulse_start();
      send_bits({24'h100000, 8'hA2}, 20, 1'b0, 20'h0);
      rst_n = 1'b0;
      tick();
      chk("t5_rst_key_p", key_p, 4'h0);
      chk("t5_rst_key_x", key_x, 20'h0);
      chk("t5_rst_valid", key_valid, 1'b0);
      chk("t5_rst_ready", ser_ready, 1'b0);
      chk("t5_rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();
      run_frame({24'h100000, 8'hA2});
      chk("t5_valid", key_valid, 1'b1);
      chk("t5_key_p", key_p, 4'h1);
      chk("t5_key_x", key_x, 20'h0);
      $display("txn 5: reset mid-frame then key_p=%h", key_p);

`ifdef LOCK_KEY_LOCKOUT_EN
      // 6: lockout after three consecutive failures; an intervening pass resets the count
      run_frame({24'h100000, 8'hA3});
      run_frame({24'h100000, 8'hA3});
      chk("t6_two_fail_lock", locked_out, 1'b0);
      chk("t6_two_fail_err", err, 1'b1);
      run_frame({24'h100000, 8'hA2});
      chk("t6_pass_lock", locked_out, 1'b0);
      chk("t6_pass_valid", key_valid, 1'b1);
      run_frame({24'h100000, 8'hA3});
      run_frame({24'h100000, 8'hA3});
      chk("t6_after_pass_lock", locked_out, 1'b0);
      run_frame({24'h100000, 8'hA3});
      chk("t6_locked", locked_out, 1'b1);
      chk("t6_locked_ready", ser_ready, 1'b0);
      chk("t6_locked_valid", key_valid, 1'b0);
      chk("t6_locked_key_p", key_p, 4'h0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      tick();
      chk("t6_ignore_start_ready", ser_ready, 1'b0);
      chk("t6_ignore_start_busy", busy, 1'b0);
      chk("t6_still_locked", locked_out, 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_rst_unlock", locked_out, 1'b0);
      $display("txn 6: lockout after three failures, cleared by reset");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
